mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single host memory-controller command port (op / address / 32-bit data / ready / tx_done / rd_valid) between two requesters: CPU (requester 0) and the accelerator block (requester 1).
- Sits between cpu, accelerators and mem_ctrl inside miner.
- Round-robin arbitration, one outstanding transaction at a time. The granted requester owns the port until the transaction completes.

Parameters:
- ADDR_W, 16, requester/controller address width
- DATA_W, 32, data word width
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT state (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  2  per-requester request; held until done_o[n]
- op_i  in  2x2  per-requester op (arb_pkg::op_t: OP_NONE=00, OP_RD=01, OP_WR=10)
- addr_i  in  2xADDR_W  per-requester address
- wdata_i  in  2xDATA_W  per-requester write data
- gnt_o  out  2  one-hot: the requester currently owns the port
- done_o  out  2  one-cycle completion pulse to the owner
- rdata_o  out  DATA_W  read data, valid with done_o on a read
- mc_op_o  out  2  op to mem_ctrl
- mc_addr_o  out  ADDR_W  address to mem_ctrl
- mc_wdata_o  out  DATA_W  write data to mem_ctrl
- mc_ready_i  in  1  mem_ctrl idle / ready to accept an op
- mc_tx_done_i  in  1  mem_ctrl write complete
- mc_rd_valid_i  in  1  mem_ctrl read data valid
- mc_rdata_i  in  DATA_W  mem_ctrl read data

Behaviour:
- Reset values (synchronous on rst=1): state=IDLE, prio=0 (CPU favoured), gnt_o=0, done_o=0, rdata_o=0, mc_op_o=OP_NONE, mc_addr_o=0, mc_wdata_o=0, timeout counter=0.
- A reset asserted mid-transaction abandons the transaction; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Leaves IDLE when (req_i[n] && op_i[n]!=OP_NONE) for some n AND mc_ready_i=1.
  - Winner: the requester named by prio if it is requesting, else the other one.
  - On the transition, register owner, op, addr and wdata; set gnt_o[owner]; go to ISSUE.
  - mc_ready_i=0 with requests pending: stay in IDLE, no grant.
  - A request with op_i=OP_NONE is ignored.
- ISSUE (exactly 1 cycle): mc_op_o/mc_addr_o/mc_wdata_o driven from the registered values; next state WAIT.
- WAIT:
  - mc_op_o returns to OP_NONE; mc_addr_o and mc_wdata_o are held.
  - Completion is mc_rd_valid_i for OP_RD, mc_tx_done_i for OP_WR. The opposite strobe is ignored.
  - On completion, in the next cycle: done_o[owner]=1 for one cycle; rdata_o<=mc_rdata_i on reads (held afterwards until the next read); gnt_o cleared; prio<=~owner; state IDLE.
  - Completion strobe arriving in the ISSUE cycle: ignored; only WAIT-state strobes count.
- Latency: grant 1 cycle after request+ready; op on the bus 1 cycle after that; done 1 cycle after the completion strobe.
- Requester inputs are sampled only at grant; changes during a transaction have no effect.
- Back-to-back: from done, the next grant happens no earlier than the following cycle (an IDLE cycle is always present).
- Simultaneous requests alternate strictly via prio. No requester is starved: worst-case wait is 1 transaction.
- A requester dropping req_i before grant withdraws cleanly. Dropping it after grant is illegal (an assertion flags it in simulation).

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES with no completion: done_o[owner] pulses, extra output err_o pulses with it, rdata_o is unchanged, prio flips, state returns to IDLE.
  - The counter clears on entry to WAIT.
- ARB_TIMEOUT_EN undefined: no counter and no err_o port; WAIT waits indefinitely.

Decomposition:
- arb_pkg holds:
  - op_t enum (OP_NONE, OP_RD, OP_WR)
  - state_t enum (IDLE, ISSUE, WAIT)
  - requester index localparams REQ_CPU=0, REQ_ACC=1
- Sub-module rr_pick2: combinational two-way round-robin select (req[1:0], prio -> winner, valid). All remaining logic stays in mem_port_arbiter.

Test Plan:
- Single CPU read, addr=0x0010, mc_rd_valid_i 5 cycles after ISSUE with rdata=0xDEADBEEF -> gnt_o=01, mc_op_o=01 for exactly 1 cycle, done_o=01 one cycle after the strobe, rdata_o=0xDEADBEEF.
- Simultaneous CPU write (0x20, 0x11111111) and accel write (0x30, 0x22222222) after reset -> CPU served first, then accel. mc_addr_o sequence 0x20 then 0x30; done_o pulses 01 then 10.
- Both requesters continuously requesting, 6 transactions -> grants alternate 0,1,0,1,0,1.
- mc_ready_i=0 for 10 cycles with accel requesting -> no grant until ready rises; grant on the cycle after it rises.
- Reset asserted during WAIT of an accel read -> next cycle all outputs at reset values, no done_o; a following CPU read completes normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, a write that never receives tx_done -> done_o and err_o pulse 8 cycles into WAIT; the arbiter then serves the other requester.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package arb_pkg;

  // Command encoding on the memory-controller port.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10
  } op_t;

  // Arbiter transaction states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  // Requester indices.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_ACC = 1'b1;

  // Only real reads and writes can start a transaction; the unused
  // encoding 2'b11 is treated like OP_NONE so it can never hang WAIT.
  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: the requester named by prio wins if it is
// requesting, otherwise the other one does.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       valid
);

  // Favour prio, fall back to the other requester.
  always_comb begin
    valid  = |req;
    winner = prio;
    if (req[prio]) begin
      winner = prio;
    end else if (req[~prio]) begin
      winner = ~prio;
    end else begin
      winner = prio;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory-controller command port between the CPU and the
// accelerator. Round-robin, one outstanding transaction at a time.
// Optional build macro ARB_TIMEOUT_EN adds a WAIT-state watchdog and err_o.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_i,
  input  logic [1:0][1:0]        op_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             done_o,
  output logic [DATA_W-1:0]      rdata_o,
`ifdef ARB_TIMEOUT_EN
  output logic                   err_o,
`endif
  output logic [1:0]             mc_op_o,
  output logic [ADDR_W-1:0]      mc_addr_o,
  output logic [DATA_W-1:0]      mc_wdata_o,
  input  logic                   mc_ready_i,
  input  logic                   mc_tx_done_i,
  input  logic                   mc_rd_valid_i,
  input  logic [DATA_W-1:0]      mc_rdata_i
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                prio_r;
  logic                owner_r;
  op_t                 op_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [1:0]          req_ok_s;
  logic                winner_s;
  logic                valid_s;
  logic                grant_s;
  logic                finish_s;
  logic                complete_s;
  logic                timeout_s;

  assign req_ok_s[REQ_CPU] = req_i[REQ_CPU] && op_is_valid(op_i[REQ_CPU]);
  assign req_ok_s[REQ_ACC] = req_i[REQ_ACC] && op_is_valid(op_i[REQ_ACC]);

  rr_pick2 u_pick (
    .req    (req_ok_s),
    .prio   (prio_r),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Completion strobe matching the registered op; the other strobe is ignored.
  always_comb begin
    complete_s = 1'b0;
    case (op_r)
      OP_RD:   complete_s = mc_rd_valid_i;
      OP_WR:   complete_s = mc_tx_done_i;
      default: complete_s = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;

  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while entering WAIT, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT) && !finish_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Error pulse accompanies done only when the watchdog ended the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= finish_s && !complete_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic plus the grant and finish events that drive the datapath.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_s && mc_ready_i) begin
          state_nxt_s = ISSUE;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (complete_s || timeout_s) begin
          state_nxt_s = IDLE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction capture, controller drive and completion reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r     <= REQ_CPU;
      owner_r    <= REQ_CPU;
      op_r       <= OP_NONE;
      addr_r     <= '0;
      wdata_r    <= '0;
      gnt_o      <= 2'b00;
      done_o     <= 2'b00;
      rdata_o    <= '0;
      mc_op_o    <= OP_NONE;
      mc_addr_o  <= '0;
      mc_wdata_o <= '0;
    end else begin
      done_o  <= 2'b00;
      mc_op_o <= OP_NONE;
      if (grant_s) begin
        owner_r <= winner_s;
        op_r    <= op_t'(op_i[winner_s]);
        addr_r  <= addr_i[winner_s];
        wdata_r <= wdata_i[winner_s];
        gnt_o   <= winner_s ? 2'b10 : 2'b01;
      end
      // The op is presented for one cycle; address and data stay put after.
      if (state_r == ISSUE) begin
        mc_op_o    <= op_r;
        mc_addr_o  <= addr_r;
        mc_wdata_o <= wdata_r;
      end
      if (finish_s) begin
        done_o[owner_r] <= 1'b1;
        gnt_o           <= 2'b00;
        prio_r          <= ~owner_r;
        if ((op_r == OP_RD) && complete_s) begin
          rdata_o <= mc_rdata_i;
        end
      end
    end
  end

endmodule
